// File: rtl/bf16_addsub_arbiter.sv
// Round-robin front end that time-shares one bfloat16 add/sub unit between NUM_REQ
// requesters; a tag pipe aligned with the unit's latency routes each result back to its owner.
module bf16_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 1,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_cntl,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [15:0]           alu_a,
  output logic [15:0]           alu_b,
  output logic                  alu_cntl,
  input  logic [15:0]           alu_c,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [15:0]           rsp_data,
  output logic                  busy
);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     ptr_nxt;
  logic               found;
  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] win_oh;
  logic               fire;
  logic [15:0]        sel_a;
  logic [15:0]        sel_b;
  logic               sel_cntl;
  logic [ADD_LAT:0]   tag_v;
  logic [IDW-1:0]     tag_id [ADD_LAT+1];

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    s = (s >= NUM_REQ) ? s - NUM_REQ : s;
    return IDW'(s);
  endfunction

  // Rotate requests so bit 0 is the pointer position, then take the first set bit.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    rot   = NUM_REQ'({req_valid, req_valid} >> ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      win   = (!found && rot[k]) ? wrap_add(ptr, k) : win;
      found = found | rot[k];
    end
  end

  // Grant decode plus AND-OR operand mux driven by the winner one-hot.
  always_comb begin
    win_oh    = ONE << win;
    req_ready = (en && rst_n && found) ? win_oh : {NUM_REQ{1'b0}};
    fire      = |(req_valid & req_ready);
    ptr_nxt   = (win == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : win + IDW'(1);
    sel_a     = 16'h0000;
    sel_b     = 16'h0000;
    sel_cntl  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_a    = sel_a | (req_a[16*k +: 16] & {16{win_oh[k]}});
      sel_b    = sel_b | (req_b[16*k +: 16] & {16{win_oh[k]}});
      sel_cntl = sel_cntl | (req_cntl[k] & win_oh[k]);
    end
  end

  // Pointer and operand registers only move on a handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= {IDW{1'b0}};
      alu_a    <= 16'h0000;
      alu_b    <= 16'h0000;
      alu_cntl <= 1'b0;
    end else if (fire) begin
      ptr      <= ptr_nxt;
      alu_a    <= sel_a;
      alu_b    <= sel_b;
      alu_cntl <= sel_cntl;
    end else begin
      ptr      <= ptr;
      alu_a    <= alu_a;
      alu_b    <= alu_b;
      alu_cntl <= alu_cntl;
    end
  end

  // Tag pipe: stage ADD_LAT lines up with alu_c, so its result is captured into rsp_*.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_v     <= {(ADD_LAT+1){1'b0}};
      for (int k = 0; k <= ADD_LAT; k++) tag_id[k] <= {IDW{1'b0}};
      rsp_valid <= {NUM_REQ{1'b0}};
      rsp_data  <= 16'h0000;
    end else begin
      tag_v[0]  <= fire;
      tag_id[0] <= win;
      for (int k = 1; k <= ADD_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      if (tag_v[ADD_LAT]) begin
        rsp_valid <= ONE << tag_id[ADD_LAT];
        rsp_data  <= alu_c;
      end else begin
        rsp_valid <= {NUM_REQ{1'b0}};
        rsp_data  <= rsp_data;
      end
    end
  end

  assign busy = (|tag_v) | (|rsp_valid);

endmodule

// File: tb/tb_bf16_addsub_arbiter.sv
// Bench for bf16_addsub_arbiter: directed steps then random traffic, checked against a
// queue-based reference model and a real-arithmetic stand-in for the shared add/sub unit.
module tb_bf16_addsub_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n, en;
  logic [3:0]    req_valid, req_cntl, req_ready, rsp_valid;
  logic [63:0]   req_a, req_b;
  logic [15:0]   alu_a, alu_b, alu_c, rsp_data;
  logic          alu_cntl, busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          due;
    int          gcyc;
  } exp_t;

  exp_t        q[$];
  int          cyc;
  int          m_ptr;
  logic [15:0] m_alu_a, m_alu_b, m_rsp_data;
  logic        m_alu_cntl;
  logic [3:0]  pv;
  logic [15:0] pa [N];
  logic [15:0] pb [N];
  logic        pcn [N];

  always #5 clk = ~clk;

  bf16_addsub_arbiter #(.NUM_REQ(4), .ADD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_cntl(req_cntl), .req_ready(req_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cntl(alu_cntl), .alu_c(alu_c), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  function automatic real bf2r(input logic [15:0] x);
    real v;
    int  e;
    if (x[14:7] == 8'd0) return 0.0;
    v = 1.0 + real'(int'(x[6:0])) / 128.0;
    e = int'(x[14:7]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic s;
    int   e, m;
    real  v;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    v = s ? -r : r;
    e = 127;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0) begin v = v * 2.0; e--; end
    m = $rtoi((v - 1.0) * 128.0);
    return {s, e[7:0], m[6:0]};
  endfunction

  function automatic logic [15:0] bf_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    return r2bf(c ? bf2r(a) - bf2r(b) : bf2r(a) + bf2r(b));
  endfunction

  function automatic logic [15:0] rnd_bf();
    logic [7:0] e;
    logic [6:0] m;
    logic       s;
    e = 8'($urandom_range(120, 134));
    m = 7'($urandom_range(0, 127));
    s = 1'($urandom_range(0, 1));
    return {s, e, m};
  endfunction

  // Stand-in for the shared unit: result registered one clock after its operands.
  always @(posedge clk) alu_c <= bf_op(alu_a, alu_b, alu_cntl);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(output bit hs, output int w);
    logic [3:0]  exp_rdy;
    logic [15:0] ga, gb;
    logic        gc;
    bit          exp_busy;
    exp_t        e;
    #2;
    hs = 1'b0;
    w  = 0;
    if (en === 1'b1 && rst_n === 1'b1) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (!hs && req_valid[i] === 1'b1) begin hs = 1'b1; w = i; end
      end
    end
    exp_rdy = hs ? (4'b0001 << w) : 4'b0000;
    chk("req_ready", req_ready, exp_rdy);
    chk("alu_a", alu_a, m_alu_a);
    chk("alu_b", alu_b, m_alu_b);
    chk("alu_cntl", alu_cntl, m_alu_cntl);
    exp_busy = 1'b0;
    foreach (q[j]) if (q[j].gcyc < cyc) exp_busy = 1'b1;
    chk("busy", busy, exp_busy);
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_valid", rsp_valid, 4'b0001 << q[0].id);
      chk("rsp_data", rsp_data, q[0].data);
      m_rsp_data = q[0].data;
      void'(q.pop_front());
    end else begin
      chk("rsp_idle", rsp_valid, 4'b0000);
      chk("rsp_hold", rsp_data, m_rsp_data);
    end
    ga = req_a[16*w +: 16];
    gb = req_b[16*w +: 16];
    gc = req_cntl[w];
    if (hs) begin
      e.id = w; e.data = bf_op(ga, gb, gc); e.due = cyc + 3; e.gcyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst_n === 1'b0) begin
      q.delete();
      m_ptr = 0; m_alu_a = 16'h0; m_alu_b = 16'h0; m_alu_cntl = 1'b0; m_rsp_data = 16'h0;
    end else if (hs) begin
      m_ptr = (w + 1) % N; m_alu_a = ga; m_alu_b = gb; m_alu_cntl = gc;
    end
    cyc++;
  endtask

  initial begin
    bit hs;
    int w;
    rst_n = 1'b0; en = 1'b1; req_valid = 4'b1111; req_cntl = 4'b0;
    req_a = 64'h0; req_b = 64'h0;
    cyc = 0; m_ptr = 0; m_alu_a = 16'h0; m_alu_b = 16'h0; m_alu_cntl = 1'b0; m_rsp_data = 16'h0;
    pv = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_alu_a", alu_a, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1; req_valid = 4'b0000;
    tick(hs, w);

    // single add on requester 1
    req_a[31:16] = 16'h3F80; req_b[31:16] = 16'h4000; req_cntl[1] = 1'b0; req_valid = 4'b0010;
    tick(hs, w);
    req_valid = 4'b0000;
    tick(hs, w); tick(hs, w);
    chk("add_rsp_valid", rsp_valid, 4'b0010);
    chk("add_rsp_data", rsp_data, 16'h4040);
    tick(hs, w);

    // subtract on requester 2
    req_a[47:32] = 16'h4040; req_b[47:32] = 16'h3F80; req_cntl[2] = 1'b1; req_valid = 4'b0100;
    tick(hs, w);
    req_valid = 4'b0000;
    tick(hs, w); tick(hs, w);
    chk("sub_rsp_valid", rsp_valid, 4'b0100);
    chk("sub_rsp_data", rsp_data, 16'h4000);
    tick(hs, w);

    // wrap from ptr=3 with requesters 3 and 0 pending
    req_a[63:48] = rnd_bf(); req_b[63:48] = rnd_bf(); req_a[15:0] = rnd_bf(); req_b[15:0] = rnd_bf();
    req_valid = 4'b1001;
    #1 chk("wrap_g3", req_ready, 4'b1000);
    tick(hs, w);
    req_valid = 4'b0001;
    #1 chk("wrap_g0", req_ready, 4'b0001);
    tick(hs, w);
    req_valid = 4'b1111;
    #1 chk("wrap_ptr1", req_ready, 4'b0010);
    req_valid = 4'b0000;
    repeat (3) tick(hs, w);

    // reset while an op is in flight
    req_valid = 4'b0001;
    tick(hs, w);
    req_valid = 4'b0000; rst_n = 1'b0;
    tick(hs, w);
    rst_n = 1'b1;
    repeat (4) tick(hs, w);
    chk("rmid_alu_a", alu_a, 16'h0000);
    chk("rmid_rsp_data", rsp_data, 16'h0000);
    chk("rmid_busy", busy, 1'b0);

    // all four requesters held valid for 8 clocks after reset (ptr=0)
    for (int i = 0; i < N; i++) begin req_a[16*i +: 16] = rnd_bf(); req_b[16*i +: 16] = rnd_bf(); end
    req_cntl = 4'($urandom_range(0, 15));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_order", req_ready, 4'b0001 << (k % 4));
      tick(hs, w);
      if (hs) begin req_a[16*w +: 16] = rnd_bf(); req_b[16*w +: 16] = rnd_bf(); end
    end
    req_valid = 4'b0000;
    repeat (3) tick(hs, w);

    // en drop: in-flight op drains, then grants resume from the held pointer
    req_valid = 4'b0100;
    tick(hs, w);
    en = 1'b0; req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1 chk("en_off_ready", req_ready, 4'b0000);
      tick(hs, w);
    end
    chk("en_off_busy", busy, 1'b0);
    en = 1'b1;
    #1 chk("en_resume", req_ready, 4'b1000);
    tick(hs, w);
    req_valid = 4'b0000;
    repeat (3) tick(hs, w);

    // random traffic with occasional en drops and one reset
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 9) != 0);
      rst_n = (c != 200);
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1; pa[i] = rnd_bf(); pb[i] = rnd_bf(); pcn[i] = 1'($urandom_range(0, 1));
        end
        req_a[16*i +: 16] = pa[i];
        req_b[16*i +: 16] = pb[i];
        req_cntl[i] = pcn[i];
      end
      req_valid = pv;
      tick(hs, w);
      if (hs) pv[w] = 1'b0;
    end
    rst_n = 1'b1; en = 1'b1; req_valid = 4'b0000;
    repeat (4) tick(hs, w);
    chk("final_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
